sevenseg_scan: RTL and testbench



---
 rtl/sevenseg_scan.sv | 139 +++++++++++++
 tb/tb_sevenseg_scan.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for a bank of common-anode
// seven-segment digits. One nibble and one blank bit per digit are captured
// on a load strobe. The digits are scanned round-robin, with SCAN_DIV lit
// cycles per digit followed by a single all-off gap cycle that suppresses
// ghosting.
// Optional build macro SEVENSEG_HEX_EN: when it is defined, values 10..15
// decode as hex glyphs A b C d E F. When it is undefined, those values are dark.
module sevenseg_scan #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 50000,
  parameter int INVERT_IN  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              disp,
  output logic [NUM_DIGITS-1:0]   dig
);

  localparam int CW = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] SHOW = 1'b0;
  localparam logic [0:0] GAP  = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [0:0]              state_reg;
  logic [CW-1:0]           cnt_reg;
  logic [IW-1:0]           idx_reg;
  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;

  logic [4*NUM_DIGITS-1:0] load_val;
  logic [3:0]              cur_val;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   dig_next;

  // Normalise each incoming nibble to true binary before it is stored.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_norm
    assign load_val[4*gi +: 4] = (INVERT_IN != 0) ? ~digits_in[4*gi +: 4]
                                                  : digits_in[4*gi +: 4];
  end

  // Active-low gfedcba segment pattern for one value.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
`ifdef SEVENSEG_HEX_EN
      4'd10:   seg = 7'b0001000;
      4'd11:   seg = 7'b0000011;
      4'd12:   seg = 7'b1000110;
      4'd13:   seg = 7'b0100001;
      4'd14:   seg = 7'b0000110;
      default: seg = 7'b0001110;
`else
      default: seg = 7'b1111111;
`endif
    endcase
    return seg;
  endfunction

  // Snapshot: reset leaves every digit blanked until the first load.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
      blank_reg <= '1;
    end else if (load) begin
      value_reg <= load_val;
      blank_reg <= blank_in;
    end
  end

  // Scan FSM: SCAN_DIV cycles lit, one gap cycle, then advance to the next digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SHOW;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        SHOW: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= SHOW;
          idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
      endcase
    end
  end

  // Select the current digit's value and blank bit, plus its one-cold enable.
  always_comb begin
    cur_val   = '0;
    cur_blank = 1'b1;
    dig_next  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_val     = value_reg[4*i +: 4];
        cur_blank   = blank_reg[i];
        dig_next[i] = 1'b0;
      end
    end
  end

  // Registered outputs: dark during the gap and for blanked digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= 7'b1111111;
      dig  <= '1;
    end else if (state_reg == GAP || cur_blank) begin
      disp <= 7'b1111111;
      dig  <= '1;
    end else begin
      disp <= decode(cur_val);
      dig  <= dig_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: scoreboard bench for sevenseg_scan, using NUM_DIGITS=6 and
// SCAN_DIV=4. It drives two instances from the same inputs. One instance takes
// true-binary nibbles and the other takes active-low nibbles. The stimulus side
// pushes the expected outputs of each clock edge. A negedge monitor pops and
// compares them.
module tb_sevenseg_scan;

  typedef struct packed {
    logic [6:0] disp;
    logic [5:0] dig;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [23:0] digits_in = '0;
  logic [5:0]  blank_in = '0;
  logic [6:0]  disp_b, disp_i;
  logic [5:0]  dig_b, dig_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  exp_t q_b[$];
  exp_t q_i[$];

  // Model state: stored values per build, blank snapshot, and cycles since reset release.
  logic [23:0] mv_b = '0;
  logic [23:0] mv_i = '0;
  logic [5:0]  mb = 6'h3F;
  int          k = 0;

  always #5 clk = ~clk;

  sevenseg_scan #(.NUM_DIGITS(6), .SCAN_DIV(4), .INVERT_IN(0)) dut_bin (
    .clk(clk), .rst(rst), .digits_in(digits_in), .blank_in(blank_in),
    .load(load), .disp(disp_b), .dig(dig_b)
  );

  sevenseg_scan #(.NUM_DIGITS(6), .SCAN_DIV(4), .INVERT_IN(1)) dut_inv (
    .clk(clk), .rst(rst), .digits_in(digits_in), .blank_in(blank_in),
    .load(load), .disp(disp_i), .dig(dig_i)
  );

  // Hand-written glyph table.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
`ifdef SEVENSEG_HEX_EN
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
`else
      default: return 7'b1111111;
`endif
    endcase
  endfunction

  // A scan slot spans 5 cycles (4 lit, 1 gap), so 6 digits give a 30-cycle period.
  function automatic exp_t expect_out(input logic r, input logic [23:0] mv,
                                      input logic [5:0] b, input int kk);
    exp_t e;
    int phase, d;
    e.disp = 7'b1111111;
    e.dig  = 6'b111111;
    phase  = kk % 5;
    d      = (kk / 5) % 6;
    if (!r && phase != 4 && !b[d]) begin
      e.dig  = ~(6'b000001 << d);
      e.disp = glyph(mv[4*d +: 4]);
    end
    return e;
  endfunction

  // One clock of stimulus: drive inputs, then record what the edge must produce.
  task automatic step(input logic r, input logic l, input logic [23:0] d,
                      input logic [5:0] b);
    exp_t eb, ei;
    @(negedge clk);
    rst = r; load = l; digits_in = d; blank_in = b;
    eb = expect_out(r, mv_b, mb, k);
    ei = expect_out(r, mv_i, mb, k);
    @(posedge clk);
    q_b.push_back(eb);
    q_i.push_back(ei);
    if (r) begin
      k = 0; mv_b = '0; mv_i = '0; mb = 6'h3F;
    end else begin
      k = k + 1;
      if (l) begin
        mv_b = d; mv_i = ~d; mb = b;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h5A5A5A, 6'b101010);
  endtask

  // Monitor: each negedge checks the outputs of the preceding posedge.
  always @(negedge clk) begin
    if (q_b.size() > 0 && q_i.size() > 0) begin
      exp_t eb, ei;
      eb = q_b.pop_front();
      ei = q_i.pop_front();
      vectors++;
      if ({disp_b, dig_b} !== {eb.disp, eb.dig}) begin
        miscompares++;
        $display("FAIL bin_out cyc=%0d got disp=%b dig=%b want disp=%b dig=%b",
                 cyc, disp_b, dig_b, eb.disp, eb.dig);
      end
      vectors++;
      if ({disp_i, dig_i} !== {ei.disp, ei.dig}) begin
        miscompares++;
        $display("FAIL inv_out cyc=%0d got disp=%b dig=%b want disp=%b dig=%b",
                 cyc, disp_i, dig_i, ei.disp, ei.dig);
      end
      vectors++;
      if ($countones(~dig_b) > 1 || $countones(~dig_i) > 1) begin
        miscompares++;
        $display("FAIL one_dig_low cyc=%0d got dig_b=%b dig_i=%b want at most one low",
                 cyc, dig_b, dig_i);
      end
      $display("cyc=%0d bin disp=%b dig=%b | inv disp=%b dig=%b",
               cyc, disp_b, dig_b, disp_i, dig_i);
    end
    cyc++;
  end

  initial begin
    // Reset for 3 cycles with load high: everything stays dark.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'hABCDEF, 6'b000000);
    // After release, dark until the first load.
    run(7);
    // Digits 654321 (bin), scanned over more than two full periods.
    step(1'b0, 1'b1, 24'h123456, 6'b000000);
    run(65);
    // Nibble 0 = F (inv: 0) and nibble 1 = 6 (inv: 9), with mixed digits elsewhere.
    step(1'b0, 1'b1, 24'h78906F, 6'b000000);
    run(35);
    // Blank digit 2; value A in digit 0 and hex values elsewhere.
    step(1'b0, 1'b1, 24'hBCDE3A, 6'b000100);
    run(35);
    // Reset mid-scan in the idx 3 SHOW slot, coincident with a load: rst wins.
    while ((k % 30) != 16) run(1);
    step(1'b1, 1'b1, 24'h999999, 6'b000000);
    run(12);
    // New load restarts a visible scan from the current position.
    step(1'b0, 1'b1, 24'h654321, 6'b000000);
    run(35);
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (q_b.size() != 0 || q_i.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d/%0d pending want 0", q_b.size(), q_i.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
